// File: rtl/pll_reset_sequencer_if.sv
// Handshake bundle between the PLL reset sequencer and its surroundings:
// the lock/restart inputs and the sequenced domain resets it produces.
interface pll_reset_sequencer_if #(
  parameter int NUM_RST = 3,
  parameter int LOSS_W  = 8
) ();
  logic               locked;
  logic               soft_rst;
  logic [NUM_RST-1:0] rst_out;
  logic               ready;
  logic [LOSS_W-1:0]  loss_count;

  // Environment side: supplies lock and restart, observes the resets.
  modport master (
    output locked, soft_rst,
    input  rst_out, ready, loss_count
  );

  // Sequencer side.
  modport slave (
    input  locked, soft_rst,
    output rst_out, ready, loss_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: synchronises the PLL lock flag, waits for it to be
// stable, then releases the domain resets one at a time (bit 0 first).
// A lock loss or a soft restart re-asserts every reset at once and the
// sequence starts again from WAIT. Lock losses are counted, saturating.
module pll_reset_sequencer #(
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGGER       = 16,
  parameter int NUM_RST       = 3,
  parameter int LOSS_W        = 8
) (
  input logic                  clock,
  input logic                  resetn,
  pll_reset_sequencer_if.slave seq
);

  localparam int CNT_MAX = (STABLE_CYCLES > STAGGER) ? STABLE_CYCLES : STAGGER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_RST + 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_STABLE,
    ST_STAGGER,
    ST_RUN
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [NUM_RST-1:0] rst_q;
  logic               ready_q;
  logic [LOSS_W-1:0]  loss_q;

  logic               locked_p0;
  logic               locked_p1;
  logic               locked_s;
  logic               abort;

  // Saturating increment: the loss counter sticks at all ones.
  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Two-flop synchroniser: the only place raw `locked` is sampled.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      locked_p0 <= 1'b0;
      locked_p1 <= 1'b0;
    end else begin
      locked_p0 <= seq.locked;
      locked_p1 <= locked_p0;
    end
  end

  // ---- stage boundary: synchronised lock feeds the sequencing FSM ----
  assign locked_s = locked_p1;
  assign abort    = !locked_s || seq.soft_rst;

  // Sequencing FSM; every output is a register of this block.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_WAIT;
      cnt     <= '0;
      idx     <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          rst_q   <= '1;
          ready_q <= 1'b0;
          if (!abort) begin
            state <= ST_STABLE;
            cnt   <= CNT_W'(1);
          end
        end
        ST_STABLE: begin
          // Dropping out before any release is a restart, not a loss.
          if (abort) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end else if (cnt == CNT_W'(STABLE_CYCLES)) begin
            state    <= ST_STAGGER;
            rst_q[0] <= 1'b0;
            idx      <= IDX_W'(1);
            cnt      <= CNT_W'(1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STAGGER, ST_RUN: begin
          if (abort) begin
            // All domains go back into reset in the same cycle.
            state   <= ST_WAIT;
            cnt     <= '0;
            idx     <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            if (!locked_s) loss_q <= sat_inc(loss_q);
          end else if (state == ST_STAGGER) begin
            if (cnt == CNT_W'(STAGGER)) begin
              cnt <= CNT_W'(1);
              if (idx < IDX_W'(NUM_RST)) begin
                rst_q <= rst_q & ~(NUM_RST'(1) << idx);
                idx   <= idx + 1'b1;
              end else begin
                ready_q <= 1'b1;
                state   <= ST_RUN;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  assign seq.rst_out    = rst_q;
  assign seq.ready      = ready_q;
  assign seq.loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with small parameters.
// Reference model: tracks how many edges have elapsed since the sequence
// started and derives the expected resets from the release schedule.
module tb_pll_reset_sequencer;

  localparam int SC = 16;
  localparam int SG = 4;
  localparam int NR = 3;
  localparam int LW = 2;

  logic clock;
  logic resetn;

  int compared;
  int mismatched;

  pll_reset_sequencer_if #(.NUM_RST(NR), .LOSS_W(LW)) bus ();

  pll_reset_sequencer #(
    .STABLE_CYCLES(SC),
    .STAGGER      (SG),
    .NUM_RST      (NR),
    .LOSS_W       (LW)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .seq   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model. m_n = -1 while waiting, otherwise edges since start.
  int          m_n;
  logic        m_s1;
  logic        m_s2;
  logic [LW-1:0] m_loss;
  logic [NR-1:0] exp_rst;
  logic        exp_ready;
  logic [LW-1:0] exp_loss;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_n    <= -1;
      m_s1   <= 1'b0;
      m_s2   <= 1'b0;
      m_loss <= '0;
    end else begin
      m_s1 <= bus.locked;
      m_s2 <= m_s1;
      if (m_n < 0) begin
        if (m_s2 && !bus.soft_rst) m_n <= 0;
      end else if (!m_s2 || bus.soft_rst) begin
        m_n <= -1;
        if (!m_s2 && m_n >= SC && m_loss != {LW{1'b1}}) m_loss <= m_loss + 1'b1;
      end else if (m_n < 10000) begin
        m_n <= m_n + 1;
      end
    end
  end

  always_comb begin
    exp_rst = '1;
    for (int k = 0; k < NR; k++)
      if (m_n >= SC + k * SG) exp_rst[k] = 1'b0;
    exp_ready = (m_n >= SC + NR * SG);
    exp_loss  = m_loss;
  end

  task automatic do_reset();
    bus.locked   = 1'b0;
    bus.soft_rst = 1'b0;
    resetn       = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    bus.locked   = 1'b0;
    bus.soft_rst = 1'b0;
    resetn       = 1'b0;
    repeat (3) begin
      @(negedge clock);
      compared++;
      if ({bus.rst_out, bus.ready, bus.loss_count} !== {3'b111, 1'b0, 2'd0}) begin
        mismatched++;
        $display("FAIL reset: got rst=%b rdy=%b loss=%0d, need rst=111 rdy=0 loss=0",
                 bus.rst_out, bus.ready, bus.loss_count);
      end
    end
  endtask

  task automatic test_powerup();
    int dr;
    resetn = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      @(negedge clock);
      compared++;
      if ({bus.rst_out, bus.ready, bus.loss_count} !== {exp_rst, exp_ready, exp_loss}) begin
        mismatched++;
        $display("FAIL powerup edge %0d: got rst=%b rdy=%b loss=%0d, need rst=%b rdy=%b loss=%0d",
                 e, bus.rst_out, bus.ready, bus.loss_count, exp_rst, exp_ready, exp_loss);
      end
      dr = -1;
      case (e)
        27:     dr = 7;
        28, 31: dr = 6;
        32, 35: dr = 4;
        36, 40: dr = 0;
        default: dr = -1;
      endcase
      if (dr >= 0) begin
        compared++;
        if (bus.rst_out !== 3'(dr)) begin
          mismatched++;
          $display("FAIL powerup_sched edge %0d: got rst=%b, need %b", e, bus.rst_out, 3'(dr));
        end
      end
      if (e == 39 || e == 40) begin
        compared++;
        if (bus.ready !== (e == 40)) begin
          mismatched++;
          $display("FAIL powerup_ready edge %0d: got %b, need %b", e, bus.ready, (e == 40));
        end
      end
      if (e == 45) begin
        compared++;
        if (bus.loss_count !== 2'd0) begin
          mismatched++;
          $display("FAIL powerup_loss: got %0d, need 0", bus.loss_count);
        end
      end
      if (e == 9) bus.locked = 1'b1;
    end
  endtask

  task automatic test_glitch();
    do_reset();
    bus.locked = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      @(negedge clock);
      compared++;
      if ({bus.rst_out, bus.ready, bus.loss_count} !== {exp_rst, exp_ready, exp_loss}) begin
        mismatched++;
        $display("FAIL glitch edge %0d: got rst=%b rdy=%b loss=%0d, need rst=%b rdy=%b loss=%0d",
                 e, bus.rst_out, bus.ready, bus.loss_count, exp_rst, exp_ready, exp_loss);
      end
      if (e == 29 || e == 30) begin
        compared++;
        if (bus.rst_out[0] !== (e == 29)) begin
          mismatched++;
          $display("FAIL glitch_release edge %0d: got rst0=%b, need %b", e, bus.rst_out[0], (e == 29));
        end
      end
      if (e == 50) begin
        compared++;
        if ({bus.ready, bus.loss_count} !== {1'b1, 2'd0}) begin
          mismatched++;
          $display("FAIL glitch_end: got rdy=%b loss=%0d, need rdy=1 loss=0", bus.ready, bus.loss_count);
        end
      end
      if (e == 10) bus.locked = 1'b0;
      if (e == 11) bus.locked = 1'b1;
    end
  endtask

  task automatic test_loss_run();
    bus.locked = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clock);
      compared++;
      if ({bus.rst_out, bus.ready, bus.loss_count} !== {exp_rst, exp_ready, exp_loss}) begin
        mismatched++;
        $display("FAIL loss_run edge %0d: got rst=%b rdy=%b loss=%0d, need rst=%b rdy=%b loss=%0d",
                 j, bus.rst_out, bus.ready, bus.loss_count, exp_rst, exp_ready, exp_loss);
      end
      if (j == 2) begin
        compared++;
        if ({bus.rst_out, bus.ready} !== {3'b000, 1'b1}) begin
          mismatched++;
          $display("FAIL loss_early: got rst=%b rdy=%b, need rst=000 rdy=1", bus.rst_out, bus.ready);
        end
      end
      if (j == 3) begin
        compared++;
        if ({bus.rst_out, bus.ready, bus.loss_count} !== {3'b111, 1'b0, 2'd1}) begin
          mismatched++;
          $display("FAIL loss_assert: got rst=%b rdy=%b loss=%0d, need rst=111 rdy=0 loss=1",
                   bus.rst_out, bus.ready, bus.loss_count);
        end
      end
    end
    bus.locked = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clock);
      compared++;
      if ({bus.rst_out, bus.ready, bus.loss_count} !== {exp_rst, exp_ready, exp_loss}) begin
        mismatched++;
        $display("FAIL loss_replay cyc %0d: got rst=%b rdy=%b loss=%0d, need rst=%b rdy=%b loss=%0d",
                 c, bus.rst_out, bus.ready, bus.loss_count, exp_rst, exp_ready, exp_loss);
      end
    end
    compared++;
    if ({bus.rst_out, bus.ready} !== {3'b000, 1'b1}) begin
      mismatched++;
      $display("FAIL loss_replay_end: got rst=%b rdy=%b, need rst=000 rdy=1", bus.rst_out, bus.ready);
    end
  endtask

  task automatic test_saturation();
    logic [LW-1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    bus.locked = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 40; c++) begin
        @(negedge clock);
        compared++;
        if ({bus.rst_out, bus.ready, bus.loss_count} !== {exp_rst, exp_ready, exp_loss}) begin
          mismatched++;
          $display("FAIL sat_run %0d cyc %0d: got rst=%b rdy=%b loss=%0d, need rst=%b rdy=%b loss=%0d",
                   i, c, bus.rst_out, bus.ready, bus.loss_count, exp_rst, exp_ready, exp_loss);
        end
      end
      if (i == 5) break;
      bus.locked = 1'b0;
      repeat (3) @(negedge clock);
      compared++;
      if (bus.loss_count !== sat_exp[i]) begin
        mismatched++;
        $display("FAIL sat_count %0d: got %0d, need %0d", i, bus.loss_count, sat_exp[i]);
      end
      bus.locked = 1'b1;
    end
  endtask

  task automatic test_soft_mid();
    bit hit;
    do_reset();
    bus.locked = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 80 && !hit; c++) begin
      @(negedge clock);
      compared++;
      if ({bus.rst_out, bus.ready, bus.loss_count} !== {exp_rst, exp_ready, exp_loss}) begin
        mismatched++;
        $display("FAIL soft_pre cyc %0d: got rst=%b rdy=%b loss=%0d, need rst=%b rdy=%b loss=%0d",
                 c, bus.rst_out, bus.ready, bus.loss_count, exp_rst, exp_ready, exp_loss);
      end
      if (exp_rst == 3'b110) hit = 1'b1;
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("FAIL soft_timeout: got no 110 phase, need one within 80 cycles");
    end
    bus.soft_rst = 1'b1;
    @(negedge clock);
    bus.soft_rst = 1'b0;
    compared++;
    if ({bus.rst_out, bus.ready, bus.loss_count} !== {3'b111, 1'b0, 2'd0}) begin
      mismatched++;
      $display("FAIL soft_abort: got rst=%b rdy=%b loss=%0d, need rst=111 rdy=0 loss=0",
               bus.rst_out, bus.ready, bus.loss_count);
    end
    for (int c = 0; c < 45; c++) begin
      @(negedge clock);
      compared++;
      if ({bus.rst_out, bus.ready, bus.loss_count} !== {exp_rst, exp_ready, exp_loss}) begin
        mismatched++;
        $display("FAIL soft_replay cyc %0d: got rst=%b rdy=%b loss=%0d, need rst=%b rdy=%b loss=%0d",
                 c, bus.rst_out, bus.ready, bus.loss_count, exp_rst, exp_ready, exp_loss);
      end
    end
    compared++;
    if ({bus.ready, bus.loss_count} !== {1'b1, 2'd0}) begin
      mismatched++;
      $display("FAIL soft_end: got rdy=%b loss=%0d, need rdy=1 loss=0", bus.ready, bus.loss_count);
    end
  endtask

  task automatic test_simul();
    // Sequencer is in RUN with loss_count 0 after the previous task.
    bus.locked = 1'b0;
    @(negedge clock);
    @(negedge clock);
    bus.soft_rst = 1'b1;
    @(negedge clock);
    bus.soft_rst = 1'b0;
    compared++;
    if ({bus.rst_out, bus.ready, bus.loss_count} !== {3'b111, 1'b0, 2'd1}) begin
      mismatched++;
      $display("FAIL simul: got rst=%b rdy=%b loss=%0d, need rst=111 rdy=0 loss=1",
               bus.rst_out, bus.ready, bus.loss_count);
    end
    bus.locked = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clock);
      compared++;
      if ({bus.rst_out, bus.ready, bus.loss_count} !== {exp_rst, exp_ready, exp_loss}) begin
        mismatched++;
        $display("FAIL simul_replay cyc %0d: got rst=%b rdy=%b loss=%0d, need rst=%b rdy=%b loss=%0d",
                 c, bus.rst_out, bus.ready, bus.loss_count, exp_rst, exp_ready, exp_loss);
      end
    end
  endtask

  task automatic test_async();
    bit hit;
    hit = 1'b0;
    // Loss count is 1 here, so the async clear is observable.
    bus.locked = 1'b0;
    repeat (3) @(negedge clock);
    bus.locked = 1'b1;
    for (int c = 0; c < 80 && !hit; c++) begin
      @(negedge clock);
      compared++;
      if ({bus.rst_out, bus.ready, bus.loss_count} !== {exp_rst, exp_ready, exp_loss}) begin
        mismatched++;
        $display("FAIL async_pre cyc %0d: got rst=%b rdy=%b loss=%0d, need rst=%b rdy=%b loss=%0d",
                 c, bus.rst_out, bus.ready, bus.loss_count, exp_rst, exp_ready, exp_loss);
      end
      if (exp_rst == 3'b100) hit = 1'b1;
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("FAIL async_timeout: got no 100 phase, need one within 80 cycles");
    end
    #2 resetn = 1'b0;
    #1;
    compared++;
    if ({bus.rst_out, bus.ready, bus.loss_count} !== {3'b111, 1'b0, 2'd0}) begin
      mismatched++;
      $display("FAIL async_clear: got rst=%b rdy=%b loss=%0d, need rst=111 rdy=0 loss=0",
               bus.rst_out, bus.ready, bus.loss_count);
    end
    #1 resetn = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clock);
      compared++;
      if ({bus.rst_out, bus.ready, bus.loss_count} !== {exp_rst, exp_ready, exp_loss}) begin
        mismatched++;
        $display("FAIL async_restart cyc %0d: got rst=%b rdy=%b loss=%0d, need rst=%b rdy=%b loss=%0d",
                 c, bus.rst_out, bus.ready, bus.loss_count, exp_rst, exp_ready, exp_loss);
      end
    end
    compared++;
    if (bus.ready !== 1'b1) begin
      mismatched++;
      $display("FAIL async_end: got rdy=%b, need 1", bus.ready);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      compared++;
      if ({bus.rst_out, bus.ready, bus.loss_count} !== {exp_rst, exp_ready, exp_loss}) begin
        mismatched++;
        $display("FAIL random cyc %0d: got rst=%b rdy=%b loss=%0d, need rst=%b rdy=%b loss=%0d",
                 c, bus.rst_out, bus.ready, bus.loss_count, exp_rst, exp_ready, exp_loss);
      end
      if (bus.locked) begin
        if ($urandom_range(0, 69) == 0) bus.locked = 1'b0;
      end else begin
        if ($urandom_range(0, 2) == 0) bus.locked = 1'b1;
      end
      bus.soft_rst = ($urandom_range(0, 199) == 0);
    end
    bus.soft_rst = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    bus.locked   = 1'b0;
    bus.soft_rst = 1'b0;
    resetn       = 1'b0;
    test_reset();
    test_powerup();
    test_glitch();
    test_loss_run();
    test_saturation();
    test_soft_mid();
    test_simul();
    test_async();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the board PLL and consumes its `locked` output.
- Runs on one PLL output clock (the 50 MHz design clock).
- Synchronises `locked`, requires it to stay stable, then releases NUM_RST active-high domain resets one after another (memory controller first, core last).
- Any lock loss or soft-reset request re-asserts every domain reset at once, and the sequence restarts.

Parameters:
- STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before the first release (>=1).
- STAGGER, 16: cycles between successive reset releases, and from the last release to `ready` (>=1).
- NUM_RST, 3: number of sequenced reset outputs (>=1).
- LOSS_W, 8: width of the lock-loss counter.

Ports:
- clock  in  1  design clock, one PLL output.
- resetn  in  1  asynchronous, active-low reset.
- locked  in  1  PLL lock; asynchronous to `clock`.
- soft_rst  in  1  synchronous, active-high restart request; a single-cycle pulse is sufficient.
- rst_out  out  NUM_RST  active-high domain resets; bit 0 is released first.
- ready  out  1  high once all resets are released.
- loss_count  out  LOSS_W  number of lock losses since `resetn`, saturating.

Behaviour:
- Asynchronous reset (`resetn` low):
  - rst_out = all ones; ready = 0; loss_count = 0.
  - Synchroniser flops = 0; state = WAIT; counters = 0.
  - Applies immediately, mid-sequence included.
- Synchroniser: `locked` passes through 2 flops to give `locked_s`. Latency is 2 edges, and nothing else samples raw `locked`.
- FSM states: WAIT, STABLE, STAGGER, RUN.
- WAIT:
  - rst_out = all ones; ready = 0.
  - When locked_s = 1 and soft_rst = 0, go to STABLE with cnt = 1.
- STABLE:
  - If locked_s = 0 or soft_rst = 1, go to WAIT with cnt = 0. This is not counted as a loss.
  - Else if cnt == STABLE_CYCLES, go to STAGGER: clear rst_out[0], set idx = 1, cnt = 1.
  - Else cnt++.
- STAGGER:
  - When cnt == STAGGER: if idx < NUM_RST, clear rst_out[idx] and idx++; otherwise set ready = 1 and go to RUN.
  - Reset cnt to 1 on each of those events; otherwise cnt++.
- RUN: hold rst_out = 0 and ready = 1.
- Timing relative to locked_s, when locked_s is first high in cycle c and stays high:
  - rst_out[k] is low from cycle c + STABLE_CYCLES + k*STAGGER.
  - ready is high from cycle c + STABLE_CYCLES + NUM_RST*STAGGER.
- Released resets never re-assert individually. Release order is strictly 0 → NUM_RST-1.
- Abort in STAGGER or RUN when locked_s = 0 or soft_rst = 1. On the next edge:
  - rst_out = all ones and ready = 0, all bits in the same cycle.
  - State → WAIT; cnt = 0; idx = 0.
  - loss_count increments only when the cause is locked_s = 0, and saturates at all ones.
- Simultaneous loss and soft_rst in the same cycle count as one loss.
- soft_rst held high keeps the block in WAIT.
- Counter widths: cnt is wide enough for max(STABLE_CYCLES, STAGGER) with no wrap. No arithmetic wraps anywhere.
- All outputs are driven directly from flops, with no combinational path from an input to an output.

Test Plan:
Bench parameters for all cases: STABLE_CYCLES = 16, STAGGER = 4, NUM_RST = 3, LOSS_W = 2.
- Power-up sequence: release resetn, raise locked at edge 10.
  - Expect locked_s at edge 12.
  - Expect rst_out = 110 at 28, 100 at 32, 000 at 36.
  - Expect ready = 1 at 40 and loss_count = 0.
- Glitchy lock: locked high for 10 cycles, low for 1, then high.
  - Expect no release until 16 continuous locked_s cycles after re-rise.
  - Expect loss_count to stay 0.
- Loss in RUN: drop locked once ready = 1.
  - Expect rst_out = 111 and ready = 0 exactly 3 edges after the drop (2 sync + 1 register).
  - Expect loss_count = 1.
  - Expect the full sequence to replay when locked returns.
- Saturation: cause 5 losses from RUN → loss_count reads 1, 2, 3, 3, 3.
- Mid-STAGGER events:
  - soft_rst pulse after rst_out = 110 → rst_out = 111 on the next edge, loss_count unchanged, then a full re-sequence.
  - soft_rst and a loss in the same cycle → loss_count +1 only.
- Async reset mid-sequence: pulse resetn low between clock edges while in STAGGER.
  - Expect rst_out = 111, ready = 0 and loss_count = 0 before the next edge.
  - Expect a restart from WAIT.
